mac_seq_ctrl: RTL

//  Sequencer around one 8-lane signed MAC (mac_8in). Computes a dot product of length cfg_chunks*PR.

---
 rtl/mac_ctrl_pkg.sv | 23 ++
 rtl/mac_8in.sv | 39 +++
 rtl/mac_seq_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_ctrl_pkg
// Brief   : Shared sizing constants and state encoding for the MAC sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package mac_ctrl_pkg;

    localparam int C_BW      = 8;
    localparam int C_PR      = 8;
    localparam int C_CW      = 4;
    localparam int C_BW_PSUM = 2 * C_BW + 6;
    localparam int C_ACC_W   = C_BW_PSUM + C_CW;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t HOLD  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mac_8in.sv
`default_nettype none
// ============================================================================
// Module  : mac_8in
// Brief   : Combinational PR-lane signed dot product of two packed chunks.
// Rev     : 1.0  initial release
// ============================================================================
module mac_8in
    import mac_ctrl_pkg::*;
#(
    parameter int BW      = C_BW,
    parameter int PR      = C_PR,
    parameter int BW_PSUM = 2 * BW + 6
) (
    input  logic [PR*BW-1:0]          a,
    input  logic [PR*BW-1:0]          b,
    output logic signed [BW_PSUM-1:0] psum
);

    logic signed [BW_PSUM-1:0] w_prod [PR];

    for (genvar i = 0; i < PR; i++) begin : g_lane
        logic signed [BW-1:0]   w_a;
        logic signed [BW-1:0]   w_b;
        logic signed [2*BW-1:0] w_p;
        assign w_a       = a[BW*i +: BW];
        assign w_b       = b[BW*i +: BW];
        assign w_p       = w_a * w_b;
        assign w_prod[i] = BW_PSUM'(w_p);
    end

    always_comb begin
        psum = '0;
        for (int i = 0; i < PR; i++) begin
            psum = psum + w_prod[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mac_seq_ctrl
// Brief   : Streams operand chunks through a 3-stage MAC pipeline, returns sum.
// Rev     : 1.0  initial release
// ============================================================================
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int BW = C_BW,
    parameter int PR = C_PR,
    parameter int CW = C_CW,
    localparam int BW_PSUM = 2 * BW + 6,
    localparam int ACC_W   = BW_PSUM + CW
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [CW-1:0]      cfg_chunks,
    output logic               busy,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [PR*BW-1:0]   op_a,
    input  logic [PR*BW-1:0]   op_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ACC_W-1:0]   res_data
);

    state_t                    r_state;
    logic [CW-1:0]             r_cfg;
    logic [CW-1:0]             r_cnt;
    logic                      r_op_ready;
    logic                      r_res_valid;
    logic [ACC_W-1:0]          r_res_data;
    logic [PR*BW-1:0]          r_s1_a;
    logic [PR*BW-1:0]          r_s1_b;
    logic                      r_s1_v;
    logic signed [BW_PSUM-1:0] r_s2_psum;
    logic                      r_s2_v;
    logic signed [ACC_W-1:0]   r_acc;

    logic signed [BW_PSUM-1:0] w_psum;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic                      w_take;
    logic                      w_last;

    mac_8in #(.BW(BW), .PR(PR), .BW_PSUM(BW_PSUM)) u_mac (
        .a    (r_s1_a),
        .b    (r_s1_b),
        .psum (w_psum)
    );

    assign w_take     = op_valid & r_op_ready;
    assign w_last     = w_take && ((r_cnt + CW'(1)) == r_cfg);
    assign w_acc_next = r_s2_v ? (r_acc + ACC_W'(r_s2_psum)) : r_acc;

    assign busy      = (r_state != IDLE);
    assign op_ready  = r_op_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_v    <= 1'b0;
            r_s2_psum <= '0;
            r_s2_v    <= 1'b0;
        end else begin
            r_s1_v    <= w_take;
            r_s2_v    <= r_s1_v;
            r_s2_psum <= w_psum;
            if (w_take) begin
                r_s1_a <= op_a;
                r_s1_b <= op_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cfg       <= '0;
            r_cnt       <= '0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cfg <= cfg_chunks;
                        r_cnt <= '0;
                        r_acc <= '0;
                        if (cfg_chunks != '0) begin
                            r_state    <= RUN;
                            r_op_ready <= 1'b1;
                        end else begin
                            r_state     <= HOLD;
                            r_res_valid <= 1'b1;
                            r_res_data  <= '0;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    if (w_take) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_last) begin
                        r_op_ready <= 1'b0;
                        r_state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_acc <= w_acc_next;
                    // Nothing enters after the last accept, so an S2 slot with S1 empty is the final chunk.
                    if (r_s2_v && !r_s1_v) begin
                        r_state     <= HOLD;
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_acc_next;
                    end
                end
                default: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
